// File: rtl/tick_sched_pkg.sv
// Shared types, default periods and difficulty-to-period mapping
// for the tick scheduler.
package tick_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_PAUSE
   } state_e;

   localparam int unsigned DEF_PERIOD_0    = 100_000_000;
   localparam int unsigned DEF_PERIOD_1    = 75_000_000;
   localparam int unsigned DEF_PERIOD_2    = 50_000_000;
   localparam int unsigned DEF_PERIOD_3    = 25_000_000;
   localparam int unsigned DEF_MIN_PERIOD  = 5_000_000;
   localparam int unsigned DEF_ACCEL_TICKS = 8;

   function automatic int unsigned period_sel(
      input logic [1:0]  d,
      input int unsigned p0,
      input int unsigned p1,
      input int unsigned p2,
      input int unsigned p3
   );
      int unsigned p;
      unique case (d)
         2'd0: p = p0;
         2'd1: p = p1;
         2'd2: p = p2;
         2'd3: p = p3;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/tick_scheduler_period_accel.sv
// Next accelerated period: period minus one eighth, floored.
// Only instantiated when TICK_SCHED_ACCEL_EN is defined.
module period_accel
   import tick_sched_pkg::*;
#(
   parameter int          CNT_W      = 32,
   parameter int unsigned MIN_PERIOD = DEF_MIN_PERIOD
) (
   input  logic [CNT_W-1:0] period_i,
   output logic [CNT_W-1:0] period_o
);

   logic [CNT_W-1:0] dec;

   assign dec      = period_i - (period_i >> 3);
   assign period_o = (dec < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : dec;

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel tick generator with run/pause/clear and boundary reloads.
// Optional period acceleration is enabled by defining TICK_SCHED_ACCEL_EN.
module tick_scheduler
   import tick_sched_pkg::*;
#(
   parameter int          CNT_W       = 32,
   parameter int          N_CH        = 4,
   parameter int unsigned PERIOD_0    = DEF_PERIOD_0,
   parameter int unsigned PERIOD_1    = DEF_PERIOD_1,
   parameter int unsigned PERIOD_2    = DEF_PERIOD_2,
   parameter int unsigned PERIOD_3    = DEF_PERIOD_3,
   parameter int unsigned MIN_PERIOD  = DEF_MIN_PERIOD,
   parameter int unsigned ACCEL_TICKS = DEF_ACCEL_TICKS
) (
   input  logic                     CLK100MHZ,
   input  logic                     rst_n,
   input  logic [1:0]               difficulty,
   input  logic                     run,
   input  logic                     clear,
   output logic [CNT_W-1:0]         currentcount,
   output logic                     enable,
   output logic [N_CH-1:0]          ch_enable,
   output logic [$clog2(N_CH)-1:0]  ch_idx,
   output logic [CNT_W-1:0]         period_cur,
   output logic                     busy
);

   localparam int CHW = $clog2(N_CH);

   if (N_CH < 2 || MIN_PERIOD < 2 || ACCEL_TICKS < 1) begin : g_cfg_bad
      $error("tick_scheduler: invalid N_CH/MIN_PERIOD/ACCEL_TICKS");
   end

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] per_q, per_d;
   logic             en_q, en_d;
   logic [N_CH-1:0]  chen_q, chen_d;
   logic [CHW-1:0]   idx_q, idx_d;
   logic [1:0]       diff_q, diff_d;
   logic [CNT_W-1:0] sel_per;
   logic             wrap;

   assign sel_per = CNT_W'(period_sel(difficulty, PERIOD_0, PERIOD_1,
                                      PERIOD_2, PERIOD_3));
   assign wrap    = (cnt_q == per_q - CNT_W'(1));

`ifdef TICK_SCHED_ACCEL_EN
   localparam int AW = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;

   logic [AW-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0] per_acc;

   period_accel #(
      .CNT_W      (CNT_W),
      .MIN_PERIOD (MIN_PERIOD)
   ) u_accel (
      .period_i (per_q),
      .period_o (per_acc)
   );
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      per_d   = per_q;
      en_d    = 1'b0;
      chen_d  = '0;
      idx_d   = idx_q;
      diff_d  = diff_q;
`ifdef TICK_SCHED_ACCEL_EN
      acc_d   = acc_q;
`endif
      if (clear) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         per_d   = '0;
         idx_d   = '0;
         diff_d  = 2'd0;
`ifdef TICK_SCHED_ACCEL_EN
         acc_d   = '0;
`endif
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (run) begin
                  state_d = S_RUN;
                  cnt_d   = '0;
                  per_d   = sel_per;
                  diff_d  = difficulty;
`ifdef TICK_SCHED_ACCEL_EN
                  acc_d   = '0;
`endif
               end
            end
            S_RUN: begin
               if (!run) state_d = S_PAUSE;
               // boundary fires even when run drops on this cycle
               if (wrap) begin
                  cnt_d  = '0;
                  en_d   = 1'b1;
                  chen_d = N_CH'(1) << idx_q;
                  idx_d  = (idx_q == CHW'(N_CH - 1)) ? '0 : idx_q + CHW'(1);
                  if (difficulty != diff_q) begin
                     per_d  = sel_per;
                     diff_d = difficulty;
`ifdef TICK_SCHED_ACCEL_EN
                     acc_d  = '0;
`endif
                  end else begin
`ifdef TICK_SCHED_ACCEL_EN
                     if (acc_q == AW'(ACCEL_TICKS - 1)) begin
                        per_d = per_acc;
                        acc_d = '0;
                     end else begin
                        acc_d = acc_q + AW'(1);
                     end
`endif
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_PAUSE: begin
               if (run) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK100MHZ or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         per_q   <= '0;
         en_q    <= 1'b0;
         chen_q  <= '0;
         idx_q   <= '0;
         diff_q  <= 2'd0;
`ifdef TICK_SCHED_ACCEL_EN
         acc_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         per_q   <= per_d;
         en_q    <= en_d;
         chen_q  <= chen_d;
         idx_q   <= idx_d;
         diff_q  <= diff_d;
`ifdef TICK_SCHED_ACCEL_EN
         acc_q   <= acc_d;
`endif
      end
   end

   assign currentcount = cnt_q;
   assign enable       = en_q;
   assign ch_enable    = chen_q;
   assign ch_idx       = idx_q;
   assign period_cur   = per_q;
   assign busy         = (state_q == S_RUN);

endmodule
